id_ex_decode_stage: RTL and testbench
=====================================

Name: id_ex_decode_stage

Overview:
- Instruction-decode stage of the RV32I pipeline, sitting directly upstream of the register file.
- Takes a fetched instruction from IF, drives the register file read addresses and collects the returned operands. Bypasses same-cycle writebacks, generates the immediate and control bits, and detects load-use hazards.
- Holds the result in the ID/EX pipeline register under a valid/ready handshake to EX.

Parameters:
- XLEN, 32, datapath and operand width.
- NOP_INSTR, 32'h00000013, instruction value captured when the stage holds a bubble.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0, takes effect immediately, released synchronously by the environment).
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  branch-mispredict kill from EX.
- rs1_addr  out  5  register file read address 1, combinational from in_instr[19:15].
- rs2_addr  out  5  register file read address 2, combinational from in_instr[24:20].
- rs1_data  in  XLEN  register file read data 1.
- rs2_data  in  XLEN  register file read data 2.
- wb_we  in  1  writeback write enable, same signal that drives the register file.
- wb_rd  in  5  writeback destination.
- wb_data  in  XLEN  writeback data.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  EX consumes the entry this cycle.
- out_pc  out  XLEN  registered PC.
- out_op1  out  XLEN  registered rs1 operand.
- out_op2  out  XLEN  registered rs2 operand.
- out_imm  out  XLEN  registered sign-extended immediate.
- out_rd  out  5  registered destination register.
- out_funct3  out  3  registered funct3.
- out_funct7b5  out  1  registered instr[30].
- out_ctrl  out  8  registered control bits: {reg_write, mem_read, mem_write, alu_src, branch, jal, jalr, lui_auipc}.
- illegal  out  1  registered; opcode not one of the nine RV32I classes.

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_ctrl=0, illegal=0.
  - out_rd=0, out_pc/op1/op2/imm=0, out_funct3=0, out_funct7b5=0.
- Opcode decode:
  - R 0110011 and I-ALU 0010011: reg_write.
  - LOAD 0000011: reg_write, mem_read, alu_src.
  - STORE 0100011: mem_write, alu_src.
  - BRANCH 1100011: branch.
  - JAL 1101111 and JALR 1100111: reg_write plus jal or jalr.
  - LUI 0110111 and AUIPC 0010111: reg_write, lui_auipc.
  - Any other opcode: ctrl=0 and illegal=1.
- Immediate by type:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All immediates are sign-extended to XLEN; R-type immediate is 0.
- Writeback bypass:
  - Condition: wb_we=1, wb_rd!=0 and wb_rd==rs1_addr.
  - Effect: operand 1 takes wb_data instead of rs1_data; rs2 is handled identically.
  - Address 0 always yields 0, regardless of rs*_data.
- Load-use hazard:
  - Fires when out_valid=1 and out_ctrl.mem_read=1 and out_rd!=0, and out_rd equals rs1_addr or rs2_addr.
  - Only addresses actually used by the instruction count: rs2 is ignored for I-ALU, LOAD, JALR, LUI, AUIPC and JAL; rs1 is ignored for LUI, AUIPC and JAL.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance && !hazard && !flush.
- Register update on each rising edge:
  - If flush: out_valid<=0 and the incoming instruction is dropped. Flush has priority over everything.
  - Else if advance and hazard: insert a bubble (out_valid<=0, out_ctrl<=0). The instruction is re-presented by IF next cycle.
  - Else if advance and in_valid: capture all fields, out_valid<=1.
  - Else if advance: out_valid<=0.
  - Otherwise: hold every output unchanged (EX back-pressure).
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle without hazards; exactly one bubble per load-use.
- Illegal instructions still travel as valid entries so EX can raise the trap.

Test Plan:
- Reset mid-stream: drive rst=0 while out_valid=1 -> out_valid and out_ctrl drop to 0 the same instant, without waiting for a clock edge.
- addi x5,x0,-3 (32'hFFD00293) accepted -> next cycle out_imm=32'hFFFFFFFD, out_rd=5, ctrl=8'b1000_0000, out_op1=0.
- Bypass: rs1=x7, rs1_data=20, wb_we=1, wb_rd=7, wb_data=99 -> out_op1=99. Repeat with wb_rd=0, rs1=x0 -> out_op1=0.
- Load-use stall:
  - Stimulus: lw x9,0(x2), then add x10,x9,x3, with out_ready=1.
  - Response: cycle after lw, in_ready=0. Next edge gives out_valid=0 (bubble). Following edge captures add with out_valid=1.
  - Check: the same sequence with add x10,x3,x4 shows no stall.
- Back-pressure: out_ready=0 for 3 cycles -> in_ready=0 and all outputs stable. out_ready=1 -> next instruction captured on the following edge.
- Flush and illegal:
  - flush=1 with in_valid=1 -> in_ready=0 and out_valid=0 next cycle.
  - in_instr=32'h0000007F -> illegal=1, out_ctrl=0, out_valid=1.

Source files
------------

// File: rtl/id_ex_decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours: IF request side, register file
// read/writeback side, and the ID/EX register outputs towards EX.
interface id_ex_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_op1;
    logic [XLEN-1:0] out_op2;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [7:0]      out_ctrl;
    logic            illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, rs1_data, rs2_data,
               wb_we, wb_rd, wb_data, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_op1, out_op2,
               out_imm, out_rd, out_funct3, out_funct7b5, out_ctrl, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, rs1_data, rs2_data,
               wb_we, wb_rd, wb_data, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_op1, out_op2,
               out_imm, out_rd, out_funct3, out_funct7b5, out_ctrl, illegal
    );
endinterface

// File: rtl/id_ex_decode_stage.sv
// RV32I decode stage: control/immediate decode, writeback bypass, load-use stall detection,
// and the ID/EX pipeline register behind a valid/ready handshake.
module id_ex_decode_stage #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Bubble payload comes from the canonical NOP so EX sees harmless fields.
    localparam logic [4:0]      NOP_RD  = NOP_INSTR[11:7];
    localparam logic [2:0]      NOP_F3  = NOP_INSTR[14:12];
    localparam logic            NOP_F7  = NOP_INSTR[30];
    localparam logic [XLEN-1:0] NOP_IMM = XLEN'($signed(NOP_INSTR[31:20]));

    logic [31:0] instr;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [7:0]  ctrl_d;
    logic        illegal_d, use_rs1, use_rs2;
    logic [XLEN-1:0] op1_d, op2_d;
    logic        hazard, advance;

    logic            valid_q, f7_q, illegal_q;
    logic [7:0]      ctrl_q;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] pc_q, op1_q, op2_q, imm_q;

    assign instr = bus.in_instr;
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign bus.rs1_addr = rs1;
    assign bus.rs2_addr = rs2;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // ctrl = {reg_write, mem_read, mem_write, alu_src, branch, jal, jalr, lui_auipc}
    always_comb begin
        ctrl_d    = '0;
        illegal_d = 1'b0;
        imm32     = '0;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        unique case (instr[6:0])
            OP_R:    ctrl_d = 8'b1000_0000;
            OP_I:    begin ctrl_d = 8'b1000_0000; imm32 = imm_i; use_rs2 = 1'b0; end
            OP_LD:   begin ctrl_d = 8'b1101_0000; imm32 = imm_i; use_rs2 = 1'b0; end
            OP_ST:   begin ctrl_d = 8'b0011_0000; imm32 = imm_s; end
            OP_BR:   begin ctrl_d = 8'b0000_1000; imm32 = imm_b; end
            OP_JAL:  begin ctrl_d = 8'b1000_0100; imm32 = imm_j; use_rs1 = 1'b0; use_rs2 = 1'b0; end
            OP_JALR: begin ctrl_d = 8'b1000_0010; imm32 = imm_i; use_rs2 = 1'b0; end
            OP_LUI, OP_AUIPC: begin
                ctrl_d = 8'b1000_0001; imm32 = imm_u; use_rs1 = 1'b0; use_rs2 = 1'b0;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Register file writes land this cycle, so the read port still shows the old value.
    always_comb begin
        op1_d = bus.rs1_data;
        op2_d = bus.rs2_data;
        if (bus.wb_we && bus.wb_rd == rs1) op1_d = bus.wb_data;
        if (bus.wb_we && bus.wb_rd == rs2) op2_d = bus.wb_data;
        if (rs1 == 5'd0) op1_d = '0;
        if (rs2 == 5'd0) op2_d = '0;
    end

    assign hazard  = valid_q && ctrl_q[6] && (rd_q != 5'd0) &&
                     ((use_rs1 && rs1 == rd_q) || (use_rs2 && rs2 == rd_q));
    assign advance = !valid_q || bus.out_ready;
    assign bus.in_ready = advance && !hazard && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            rd_q      <= '0;
            f3_q      <= '0;
            f7_q      <= 1'b0;
            pc_q      <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (advance && hazard) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            rd_q      <= NOP_RD;
            f3_q      <= NOP_F3;
            f7_q      <= NOP_F7;
            imm_q     <= NOP_IMM;
        end else if (advance && bus.in_valid) begin
            valid_q   <= 1'b1;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            rd_q      <= instr[11:7];
            f3_q      <= instr[14:12];
            f7_q      <= instr[30];
            pc_q      <= bus.in_pc;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_q     <= XLEN'($signed(imm32));
        end else if (advance) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_ctrl     = ctrl_q;
    assign bus.illegal      = illegal_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_funct3   = f3_q;
    assign bus.out_funct7b5 = f7_q;
    assign bus.out_pc       = pc_q;
    assign bus.out_op1      = op1_q;
    assign bus.out_op2      = op2_q;
    assign bus.out_imm      = imm_q;
endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed and randomized bench for id_ex_decode_stage with an instruction-level reference model.
module tb_id_ex_decode_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_decode_stage_if #(.XLEN(32)) bus ();
    id_ex_decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] regs [32];
    logic obs_ready;

    // model of what the ID/EX register should hold
    logic        m_valid, m_f7, m_ill;
    logic [7:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [31:0] m_pc, m_op1, m_op2, m_imm;

    typedef struct {
        logic [7:0]  ctrl;
        logic        ill;
        logic [31:0] imm;
        logic        use1;
        logic        use2;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int s;
        int v;
        s = ins[31] ? 1 : 0;
        v = 0;
        d.ctrl = 8'h00; d.ill = 1'b0; d.use1 = 1'b1; d.use2 = 1'b1;
        case (ins[6:0])
            7'h33: d.ctrl = 8'h80;
            7'h13: begin d.ctrl = 8'h80; d.use2 = 1'b0; v = -2048*s + int'(ins[30:20]); end
            7'h03: begin d.ctrl = 8'hD0; d.use2 = 1'b0; v = -2048*s + int'(ins[30:20]); end
            7'h67: begin d.ctrl = 8'h82; d.use2 = 1'b0; v = -2048*s + int'(ins[30:20]); end
            7'h23: begin d.ctrl = 8'h30; v = -2048*s + int'(ins[30:25])*32 + int'(ins[11:7]); end
            7'h63: begin
                d.ctrl = 8'h08;
                v = -4096*s + int'(ins[7])*2048 + int'(ins[30:25])*32 + int'(ins[11:8])*2;
            end
            7'h6F: begin
                d.ctrl = 8'h84; d.use1 = 1'b0; d.use2 = 1'b0;
                v = -(1<<20)*s + int'(ins[19:12])*4096 + int'(ins[20])*2048 + int'(ins[30:21])*2;
            end
            7'h37, 7'h17: begin d.ctrl = 8'h81; d.use1 = 1'b0; d.use2 = 1'b0; v = int'(ins & 32'hFFFF_F000); end
            default: d.ill = 1'b1;
        endcase
        d.imm = 32'(v);
        return d;
    endfunction

    function automatic logic [31:0] ref_opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_we && bus.wb_rd == a) return bus.wb_data;
        return regs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_ctrl = 0; m_ill = 0; m_rd = 0; m_f3 = 0; m_f7 = 0;
        m_pc = 0; m_op1 = 0; m_op2 = 0; m_imm = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".ctrl"}, 32'(bus.out_ctrl), 32'(m_ctrl));
        if (m_valid) begin
            chk({tag, ".pc"}, bus.out_pc, m_pc);
            chk({tag, ".op1"}, bus.out_op1, m_op1);
            chk({tag, ".op2"}, bus.out_op2, m_op2);
            chk({tag, ".imm"}, bus.out_imm, m_imm);
            chk({tag, ".rd"}, 32'(bus.out_rd), 32'(m_rd));
            chk({tag, ".f3"}, 32'(bus.out_funct3), 32'(m_f3));
            chk({tag, ".f7b5"}, 32'(bus.out_funct7b5), 32'(m_f7));
            chk({tag, ".illegal"}, 32'(bus.illegal), 32'(m_ill));
        end
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check after.
    task automatic cycle(input string tag);
        dec_t d;
        logic hz, adv, rdy;
        logic [31:0] ins;
        ins = bus.in_instr;
        bus.rs1_data = regs[ins[19:15]];
        bus.rs2_data = regs[ins[24:20]];
        #1;
        d   = ref_decode(ins);
        hz  = m_valid && m_ctrl[6] && m_rd != 0 &&
              ((d.use1 && ins[19:15] == m_rd) || (d.use2 && ins[24:20] == m_rd));
        adv = !m_valid || bus.out_ready;
        rdy = adv && !hz && !bus.flush;
        obs_ready = bus.in_ready;
        chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
        chk({tag, ".rs_addr"}, {22'd0, bus.rs2_addr, bus.rs1_addr}, {22'd0, ins[24:20], ins[19:15]});
        if (bus.flush) begin
            m_valid = 0;
        end else if (adv && hz) begin
            m_valid = 0; m_ctrl = 0;
        end else if (adv && bus.in_valid) begin
            m_valid = 1; m_ctrl = d.ctrl; m_ill = d.ill; m_imm = d.imm;
            m_rd = ins[11:7]; m_f3 = ins[14:12]; m_f7 = ins[30]; m_pc = bus.in_pc;
            m_op1 = ref_opnd(ins[19:15]); m_op2 = ref_opnd(ins[24:20]);
        end else if (adv) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    localparam logic [31:0] LW_X9    = 32'h0001_2483;
    localparam logic [31:0] ADD_DEP  = 32'h0034_8533;
    localparam logic [31:0] ADD_FREE = 32'h0041_8533;
    localparam logic [6:0]  OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        logic [31:0] ins;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hDEAD_BEEF;
        regs[7] = 32'd20;
        rst = 1'b0;
        bus.in_valid = 0; bus.in_instr = 32'h13; bus.in_pc = 0; bus.flush = 0;
        bus.rs1_data = 0; bus.rs2_data = 0; bus.wb_we = 0; bus.wb_rd = 0; bus.wb_data = 0;
        bus.out_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", 32'(bus.out_valid), 32'd0);
        chk("reset.ctrl", 32'(bus.out_ctrl), 32'd0);
        chk("reset.illegal", 32'(bus.illegal), 32'd0);
        chk("reset.rd_f3_f7", {24'd0, bus.out_rd, bus.out_funct3}, 32'd0);
        chk("reset.f7b5", 32'(bus.out_funct7b5), 32'd0);
        chk("reset.pc_op", bus.out_pc | bus.out_op1 | bus.out_op2 | bus.out_imm, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // addi x5,x0,-3
        bus.in_valid = 1; bus.in_instr = 32'hFFD0_0293; bus.in_pc = 32'h100;
        cycle("addi");
        chk("addi.imm_k", bus.out_imm, 32'hFFFF_FFFD);
        chk("addi.rd_k", 32'(bus.out_rd), 32'd5);
        chk("addi.ctrl_k", 32'(bus.out_ctrl), 32'h80);
        chk("addi.op1_k", bus.out_op1, 32'd0);

        // bypass: addi x1,x7,0 with x7 being written this cycle
        bus.in_instr = 32'h0003_8093; bus.wb_we = 1; bus.wb_rd = 7; bus.wb_data = 32'd99;
        cycle("byp");
        chk("byp.op1_k", bus.out_op1, 32'd99);
        bus.in_instr = 32'h0000_0093; bus.wb_rd = 0;
        cycle("byp0");
        chk("byp0.op1_k", bus.out_op1, 32'd0);
        bus.wb_we = 0;

        // load-use
        bus.in_instr = LW_X9; bus.in_pc = 32'h200;
        cycle("lw");
        bus.in_instr = ADD_DEP; bus.in_pc = 32'h204;
        cycle("lu.stall");
        chk("lu.stall_ready", 32'(obs_ready), 32'd0);
        chk("lu.bubble_valid", 32'(bus.out_valid), 32'd0);
        cycle("lu.replay");
        chk("lu.replay_ready", 32'(obs_ready), 32'd1);
        chk("lu.replay_rd", {31'd0, bus.out_valid} | (32'(bus.out_rd) << 8), 32'h0A01);
        bus.in_instr = LW_X9;
        cycle("lw2");
        bus.in_instr = ADD_FREE;
        cycle("lu.free");
        chk("lu.free_ready", 32'(obs_ready), 32'd1);
        chk("lu.free_valid", 32'(bus.out_valid), 32'd1);

        // back-pressure
        bus.in_instr = 32'h0050_0313;
        cycle("bp.first");
        bus.in_instr = 32'h0070_0393; bus.out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp.hold");
            chk("bp.hold_ready", 32'(obs_ready), 32'd0);
            chk("bp.hold_rd", 32'(bus.out_rd), 32'd6);
        end
        bus.out_ready = 1;
        cycle("bp.release");
        chk("bp.release_rd", 32'(bus.out_rd), 32'd7);

        // flush, then illegal opcode
        bus.flush = 1; bus.in_instr = 32'h0010_0413;
        cycle("flush");
        chk("flush.ready", 32'(obs_ready), 32'd0);
        chk("flush.valid", 32'(bus.out_valid), 32'd0);
        bus.flush = 0; bus.in_instr = 32'h0000_007F;
        cycle("illegal");
        chk("illegal.flag", {30'd0, bus.illegal, bus.out_valid}, 32'd3);
        chk("illegal.ctrl", 32'(bus.out_ctrl), 32'd0);

        // randomized traffic with small register indices so hazards and bypasses recur
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0]   = OPS[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            bus.in_instr  = ins;
            bus.in_pc     = $urandom;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.wb_we     = $urandom_range(0, 1) == 1;
            bus.wb_rd     = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 31)] = $urandom;
            cycle("rand");
        end

        // asynchronous reset while holding a valid entry
        bus.flush = 0; bus.in_valid = 1; bus.out_ready = 1; bus.wb_we = 0;
        bus.in_instr = 32'hFFD0_0293;
        cycle("pre_rst");
        #1 rst = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.out_valid), 32'd0);
        chk("arst.ctrl", 32'(bus.out_ctrl), 32'd0);
        model_reset();
        @(negedge clk) begin rst = 1'b1; bus.in_valid = 0; end
        @(posedge clk);
        #1;
        compare_all("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
